// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   arb_state_e : FSM encodings (ST_IDLE, ST_DMA_BURST)
//   owner_e     : which requester owns the in-flight read (OWNER_CORE, OWNER_DMA)
//   cnt_width() : bits needed to hold the values 0 .. max_count-1 (at least 1)
package dmem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_DMA_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DMA  = 1'b1
  } owner_e;

  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// arb_sat_counter: up-counter that saturates at MAX, with synchronous clear.
// Clear has priority over increment.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear to 0
//   inc        : increment by one unless already at MAX
//   cnt        : current count
module arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the core
// load/store path and a DMA/debug loader. One requester is granted per cycle;
// the memory is synchronous-read, so read data returns the cycle after grant.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   core_req/we/addr/wdata        core request side
//   core_gnt, core_stall          combinational grant; stall = req & ~gnt
//   core_rvalid, core_rdata       read return (0 when not the read owner)
//   dma_req/we/addr/wdata/last    DMA request side, dma_last marks final beat
//   dma_gnt                       combinational grant
//   dma_rvalid, dma_rdata         read return (0 when not the read owner)
//   mem_addr/we/din, mem_dout     data_mem interface
//   perf_stall_cnt, perf_dma_beats  only with DMEM_ARB_PERF_EN defined
//
// Build option: `define DMEM_ARB_PERF_EN adds the two wrapping perf counters.
//
// state        | meaning
// ST_IDLE      | core has priority; DMA wins only once starved for DMA_STARVE-1 cycles
// ST_DMA_BURST | DMA owns the port until dma_last or the MAX_BURST cap; core blocked
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 8,
  parameter int DMA_STARVE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic [DATA_W/8-1:0] core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_gnt,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                dma_req,
  input  logic [DATA_W/8-1:0] dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic                dma_last,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_dma_beats
`endif
);

  localparam int BW = cnt_width(MAX_BURST);
  localparam int SW = cnt_width(DMA_STARVE);

  arb_state_e state_q, state_d;
  owner_e     owner_q;
  logic       rd_q;
  logic       fair_q;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] starve_cnt;
  logic       starve_hit, beat_cap;

  assign starve_hit = (starve_cnt == SW'(DMA_STARVE - 1));
  assign beat_cap   = (beat_cnt == BW'(MAX_BURST - 1));

  // beat_cnt is always 0 in IDLE, so an IDLE grant is beat 0 and only caps
  // immediately when MAX_BURST == 1.
  arb_sat_counter #(.W(BW), .MAX(MAX_BURST - 1)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dma_gnt & (dma_last | beat_cap)),
    .inc   (dma_gnt),
    .cnt   (beat_cnt)
  );

  arb_sat_counter #(.W(SW), .MAX(DMA_STARVE - 1)) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dma_gnt),
    .inc   (dma_req & ~dma_gnt),
    .cnt   (starve_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fair_q  <= 1'b0;
      rd_q    <= 1'b0;
      owner_q <= OWNER_CORE;
    end else begin
      state_q <= state_d;
      // A cap exit (not a natural dma_last end) hands the next IDLE cycle to the core.
      fair_q  <= dma_gnt & beat_cap & ~dma_last;
      rd_q    <= (core_gnt & (core_we == '0)) | (dma_gnt & (dma_we == '0));
      if (core_gnt | dma_gnt) begin
        owner_q <= dma_gnt ? OWNER_DMA : OWNER_CORE;
      end
    end
  end

  // Grants are forced low while rst_n is asserted, independent of the clock.
  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: begin
          core_gnt = core_req & ~(dma_req & starve_hit & ~fair_q);
          dma_gnt  = dma_req & ~core_gnt;
          if (dma_gnt && !dma_last && !beat_cap) begin
            state_d = ST_DMA_BURST;
          end
        end
        ST_DMA_BURST: begin
          dma_gnt = dma_req;
          if (dma_gnt && (dma_last || beat_cap)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign core_stall = core_req & ~core_gnt & rst_n;

  always_comb begin
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (dma_gnt) begin
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
      mem_we   = dma_we;
    end else if (rst_n) begin
      mem_addr = core_addr;
      mem_din  = core_wdata;
      if (core_gnt) begin
        mem_we = core_we;
      end
    end
  end

  assign core_rvalid = rd_q & (owner_q == OWNER_CORE);
  assign dma_rvalid  = rd_q & (owner_q == OWNER_DMA);
  assign core_rdata  = core_rvalid ? mem_dout : '0;
  assign dma_rdata   = dma_rvalid ? mem_dout : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_dma_beats <= '0;
    end else begin
      if (core_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (dma_gnt)    perf_dma_beats <= perf_dma_beats + 32'd1;
    end
  end
`endif

endmodule
